// File: rtl/oam_dma_controller.sv
// OAM DMA sequencer: copies one source page into OAM through the shared memory port,
// stalling the CPU and owning the bus while the transfer is in flight.
module oam_dma_controller #(
    parameter int          NUM_BYTES   = 160,
    parameter logic [15:0] DST_BASE    = 16'hFE00,
    parameter int          START_DELAY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dma_start,
    input  logic [7:0]  dma_page,
    input  logic [15:0] cpu_address,
    input  logic        cpu_oe,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_wdata,
    input  logic [7:0]  mem_rdata,
    output logic [15:0] mem_address,
    output logic        mem_oe,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    output logic        cpu_stall,
    output logic        busy,
    output logic        done
);

    localparam int               IDX_W      = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_INDEX = IDX_W'(NUM_BYTES - 1);
    localparam logic [1:0]       DELAY_LOAD = (START_DELAY > 0) ? 2'(START_DELAY - 1) : 2'd0;

    typedef enum logic [2:0] {
        IDLE,
        DELAY,
        RD_ADDR,
        RD_DATA,
        WR_ADDR,
        WR_DATA,
        DONE
    } state_t;

    state_t           state, state_next;
    logic [IDX_W-1:0] index, index_next;
    logic [7:0]       src_page, src_page_next;
    logic [7:0]       latch, latch_next;
    logic [1:0]       delay_cnt, delay_cnt_next;
    logic [15:0]      src_address;
    logic [15:0]      dst_address;
    logic [15:0]      dma_address;
    logic             dma_oe;
    logic             dma_we;
    logic [7:0]       remapped_page;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            index     <= '0;
            src_page  <= 8'h00;
            latch     <= 8'h00;
            delay_cnt <= 2'd0;
        end else begin
            state     <= state_next;
            index     <= index_next;
            src_page  <= src_page_next;
            latch     <= latch_next;
            delay_cnt <= delay_cnt_next;
        end
    end

    // Pages E0..FF mirror C0..DF (echo RAM), so fold them down before reading.
    assign remapped_page = (dma_page >= 8'hE0) ? (dma_page - 8'h20) : dma_page;
    assign src_address   = {src_page, 8'h00} + 16'(index);
    assign dst_address   = DST_BASE + 16'(index);

    always_comb begin
        state_next     = state;
        index_next     = index;
        src_page_next  = src_page;
        latch_next     = latch;
        delay_cnt_next = delay_cnt;
        busy           = 1'b1;
        done           = 1'b0;
        dma_address    = 16'h0000;
        dma_oe         = 1'b0;
        dma_we         = 1'b0;

        case (state)
            IDLE: begin
                busy = 1'b0;
            end
            DELAY: begin
                if (delay_cnt == 2'd0) begin
                    state_next = RD_ADDR;
                end else begin
                    delay_cnt_next = delay_cnt - 2'd1;
                end
            end
            RD_ADDR: begin
                dma_address = src_address;
                dma_oe      = 1'b1;
                state_next  = RD_DATA;
            end
            RD_DATA: begin
                // Memory registers its address, so the byte is valid during this second read cycle.
                dma_address = src_address;
                dma_oe      = 1'b1;
                latch_next  = mem_rdata;
                state_next  = WR_ADDR;
            end
            WR_ADDR: begin
                dma_address = dst_address;
                dma_we      = 1'b1;
                state_next  = WR_DATA;
            end
            WR_DATA: begin
                dma_address = dst_address;
                dma_we      = 1'b1;
                if (index == LAST_INDEX) begin
                    state_next = DONE;
                end else begin
                    index_next = index + 1'b1;
                    state_next = RD_ADDR;
                end
            end
            DONE: begin
                busy       = 1'b0;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                busy       = 1'b0;
                state_next = IDLE;
            end
        endcase

        // A new trigger always restarts from byte 0, abandoning any transfer in flight.
        if (dma_start) begin
            src_page_next  = remapped_page;
            index_next     = '0;
            delay_cnt_next = DELAY_LOAD;
            state_next     = (START_DELAY == 0) ? RD_ADDR : DELAY;
        end
    end

    assign cpu_stall   = busy;
    assign mem_address = busy ? dma_address : cpu_address;
    assign mem_oe      = busy ? dma_oe      : cpu_oe;
    assign mem_we      = busy ? dma_we      : cpu_we;
    assign mem_wdata   = busy ? latch       : cpu_wdata;

endmodule

// File: tb/tb_oam_dma_controller.sv
// Scoreboard bench for oam_dma_controller: a transfer-level model queues the expected bus
// events with their cycle numbers; a negedge monitor pops and compares them.
module tb_oam_dma_controller;

    localparam int          NUM_BYTES   = 160;
    localparam logic [15:0] DST_BASE    = 16'hFE00;
    localparam int          START_DELAY = 1;
    localparam int          KIND_RD     = 0;
    localparam int          KIND_WR     = 1;
    localparam int          KIND_DONE   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dma_start = 1'b0;
    logic [7:0]  dma_page = 8'h00;
    logic [15:0] cpu_address = 16'h0000;
    logic        cpu_oe = 1'b0;
    logic        cpu_we = 1'b0;
    logic [7:0]  cpu_wdata = 8'h00;
    logic [7:0]  mem_rdata = 8'h00;
    logic [15:0] mem_address;
    logic        mem_oe;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic        cpu_stall;
    logic        busy;
    logic        done;

    typedef struct {
        int          kind;
        int          cyc;
        logic [15:0] addr;
        logic [7:0]  data;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        act;
    bit         have_event;
    logic [7:0] mem [0:65535];
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;
    int         last_src = 0;
    bit         mon_en = 1'b0;
    bit         cpu_rand = 1'b0;

    oam_dma_controller #(
        .NUM_BYTES   (NUM_BYTES),
        .DST_BASE    (DST_BASE),
        .START_DELAY (START_DELAY)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .dma_start   (dma_start),
        .dma_page    (dma_page),
        .cpu_address (cpu_address),
        .cpu_oe      (cpu_oe),
        .cpu_we      (cpu_we),
        .cpu_wdata   (cpu_wdata),
        .mem_rdata   (mem_rdata),
        .mem_address (mem_address),
        .mem_oe      (mem_oe),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .cpu_stall   (cpu_stall),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory unit with a registered read port.
    always @(posedge clk) begin
        mem_rdata <= mem[mem_address];
        if (mem_we === 1'b1) mem[mem_address] <= mem_wdata;
    end

    function automatic logic [63:0] packEv(input ev_t e);
        return {4'(e.kind), 32'(e.cyc), e.addr, e.data};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic randomCpu();
        int op;
        op          = $urandom_range(0, 2);
        cpu_oe      = (op == 1);
        cpu_we      = (op == 2);
        cpu_wdata   = 8'($urandom);
        cpu_address = (op == 2) ? (16'h8000 | 16'($urandom_range(0, 16'h1FFF))) : 16'($urandom);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (cpu_rand) randomCpu();
        #1;
    endtask

    task automatic trimAfter(input int t);
        while (exp_q.size() > 0 && exp_q[exp_q.size()-1].cyc > t) exp_q.delete(exp_q.size() - 1);
    endtask

    // Model: a trigger in cycle T reads byte i in cycles T+S+1+4i and T+S+2+4i,
    // writes it in the next two, and done follows the last write.
    task automatic applyStimulus(input logic [7:0] page);
        int          src;
        int          base;
        logic [15:0] sa;
        logic [15:0] da;
        trimAfter(cyc);
        src = (page >= 8'hE0) ? int'(page) - 32 : int'(page);
        for (int i = 0; i < NUM_BYTES; i++) begin
            base = cyc + START_DELAY + 1 + 4 * i;
            sa   = 16'(src * 256 + i);
            da   = 16'(int'(DST_BASE) + i);
            exp_q.push_back('{kind: KIND_RD, cyc: base,     addr: sa, data: 8'h00});
            exp_q.push_back('{kind: KIND_RD, cyc: base + 1, addr: sa, data: 8'h00});
            exp_q.push_back('{kind: KIND_WR, cyc: base + 2, addr: da, data: mem[sa]});
            exp_q.push_back('{kind: KIND_WR, cyc: base + 3, addr: da, data: mem[sa]});
        end
        exp_q.push_back('{kind: KIND_DONE, cyc: cyc + START_DELAY + 4 * NUM_BYTES + 1, addr: 16'h0, data: 8'h00});
        last_src  = src;
        dma_start = 1'b1;
        dma_page  = page;
        tick();
        dma_start = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        int n;
        n = 0;
        while ((exp_q.size() > 0 || busy !== 1'b0) && n < 2000) begin
            tick();
            n++;
        end
        checkOutput({name, "_complete"}, 64'(exp_q.size()), 64'(0));
    endtask

    task automatic checkOam(input string name, input int src);
        for (int i = 0; i < NUM_BYTES; i++)
            checkOutput(name, 64'(mem[16'(int'(DST_BASE) + i)]), 64'(mem[16'(src * 256 + i)]));
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            checkOutput("stall_eq_busy", 64'(cpu_stall), 64'(busy));
            checkOutput("oe_we_exclusive", 64'(mem_oe & mem_we), 64'(0));
            if (busy === 1'b0)
                checkOutput("cpu_passthrough", 64'({mem_address, mem_oe, mem_we, mem_wdata}),
                            64'({cpu_address, cpu_oe, cpu_we, cpu_wdata}));
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                tests++;
                fails++;
                $display("[TB] FAIL missed_event: got nothing expected %0h (cycle %0d)", packEv(exp_q[0]), cyc);
                exp_q.delete(0);
            end
            have_event = 1'b0;
            if (done === 1'b1) begin
                have_event = 1'b1;
                act = '{kind: KIND_DONE, cyc: cyc, addr: 16'h0, data: 8'h00};
            end else if (busy === 1'b1 && mem_we === 1'b1) begin
                have_event = 1'b1;
                act = '{kind: KIND_WR, cyc: cyc, addr: mem_address, data: mem_wdata};
            end else if (busy === 1'b1 && mem_oe === 1'b1) begin
                have_event = 1'b1;
                act = '{kind: KIND_RD, cyc: cyc, addr: mem_address, data: 8'h00};
            end
            if (have_event) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_event: got %0h expected nothing (cycle %0d)", packEv(act), cyc);
                end else begin
                    checkOutput("bus_event", packEv(act), packEv(exp_q[0]));
                    exp_q.delete(0);
                end
            end
        end
    end

    initial begin
        int t0;
        int n;
        int src_b;
        logic [7:0] page_a;
        logic [7:0] page_b;

        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        for (int i = 0; i < NUM_BYTES; i++) mem[16'hC000 + i] = 8'(i) ^ 8'h5A;
        mem[16'hFF80] = 8'h00;

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checkOutput("reset_busy", 64'(busy), 64'(0));
        checkOutput("reset_done", 64'(done), 64'(0));
        checkOutput("reset_stall", 64'(cpu_stall), 64'(0));
        checkOutput("reset_address", 64'(mem_address), 64'(cpu_address));
        mon_en   = 1'b1;
        cpu_rand = 1'b1;

        // Reset in the middle of a transfer abandons it with no done pulse.
        t0 = cyc;
        applyStimulus(8'hC0);
        while (cyc < t0 + 100) tick();
        rst = 1'b1;
        trimAfter(cyc);
        tick();
        rst = 1'b0;
        #1;
        checkOutput("rst_abort_busy", 64'(busy), 64'(0));
        checkOutput("rst_abort_address", 64'(mem_address), 64'(cpu_address));
        repeat (8) tick();
        checkOutput("rst_abort_queue", 64'(exp_q.size()), 64'(0));

        applyStimulus(8'hC0);
        waitIdle("basic");
        for (int i = 0; i < NUM_BYTES; i++)
            checkOutput("basic_oam", 64'(mem[16'(int'(DST_BASE) + i)]), 64'(8'(i) ^ 8'h5A));

        t0 = cyc;
        applyStimulus(8'hC0);
        while (cyc < t0 + 50) tick();
        applyStimulus(8'hC1);
        waitIdle("restart");
        checkOam("restart_oam", 16'hC1);

        applyStimulus(8'hE2);
        waitIdle("remap");
        checkOam("remap_oam", 16'hC2);

        // A CPU write held across the transfer lands only once the bus is released.
        cpu_rand = 1'b0;
        cpu_oe   = 1'b0;
        cpu_we   = 1'b0;
        applyStimulus(8'($urandom_range(8'hC0, 8'hDF)));
        repeat (20) tick();
        cpu_address = 16'hFF80;
        cpu_wdata   = 8'h33;
        cpu_we      = 1'b1;
        #1;
        checkOutput("arb_stall", 64'(cpu_stall), 64'(1));
        n = 0;
        while (cpu_stall !== 1'b0 && n < 1000) begin
            tick();
            n++;
        end
        checkOutput("arb_stall_release", 64'(cpu_stall), 64'(0));
        checkOutput("arb_no_early_write", 64'(mem[16'hFF80]), 64'(8'h00));
        tick();
        cpu_we = 1'b0;
        #1;
        checkOutput("arb_cpu_write", 64'(mem[16'hFF80]), 64'(8'h33));
        waitIdle("arb");
        cpu_rand = 1'b1;

        // Trigger landing exactly on the done cycle.
        page_a = 8'($urandom_range(8'hC0, 8'hDF));
        page_b = 8'($urandom_range(8'hC0, 8'hFF));
        t0 = cyc;
        applyStimulus(page_a);
        while (cyc < t0 + START_DELAY + 4 * NUM_BYTES + 1) tick();
        checkOutput("done_cycle_pulse", 64'(done), 64'(1));
        applyStimulus(page_b);
        checkOutput("restart_from_done_busy", 64'(busy), 64'(1));
        src_b = last_src;
        waitIdle("done_restart");
        checkOam("done_restart_oam", src_b);

        for (int k = 0; k < 6; k++) begin
            applyStimulus(8'($urandom_range(8'hC0, 8'hFF)));
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 640)) tick();
                applyStimulus(8'($urandom_range(8'hC0, 8'hFF)));
            end
            waitIdle("random");
            checkOam("random_oam", last_src);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
